// File: rtl/squareroot_ahsqr_k10.sv
// Approximate hybrid integer square root (k=10): exact root of R[15:10],
// shift-based linear approximation of the low 10 bits, one registered stage.
module squareroot_ahsqr_k10 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] R,
    output logic [7:0]  final_op,
    output logic        out_valid
);

    logic [5:0]  h;
    logic [9:0]  l;
    logic [2:0]  qh;
    logic [3:0]  rem_h;
    logic [4:0]  ql;
    logic [14:0] x;
    logic [14:0] a_full;
    logic [4:0]  a_sat;
    logic [7:0]  result;

    assign h = R[15:10];
    assign l = R[9:0];

    // Restoring square root of the 6-bit high part; remainder stays <= 2*qh.
    always_comb begin
        logic [5:0] r;
        logic [5:0] t;
        logic [2:0] q;
        r = '0;
        t = '0;
        q = '0;
        for (int i = 2; i >= 0; i--) begin
            r = {r[3:0], h[2*i +: 2]};
            t = {1'b0, q, 2'b01};
            if (r >= t) begin
                r = r - t;
                q = {q[1:0], 1'b1};
            end else begin
                q = {q[1:0], 1'b0};
            end
        end
        qh    = q;
        rem_h = r[3:0];
    end

    // Exact root of the low 10 bits, used only when the high part is zero.
    always_comb begin
        logic [7:0] r;
        logic [7:0] t;
        logic [4:0] q;
        r = '0;
        t = '0;
        q = '0;
        for (int i = 4; i >= 0; i--) begin
            r = {r[5:0], l[2*i +: 2]};
            t = {1'b0, q, 2'b01};
            if (r >= t) begin
                r = r - t;
                q = {q[3:0], 1'b1};
            end else begin
                q = {q[3:0], 1'b0};
            end
        end
        ql = q;
    end

    // The shift tracks the leading-one position of qh so the slope scales with the root.
    always_comb begin
        x = {1'b0, rem_h, l};
        if (qh[2])
            a_full = x >> 8;
        else if (qh[1])
            a_full = x >> 7;
        else
            a_full = x >> 6;
        a_sat = (a_full > 15'd31) ? 5'd31 : a_full[4:0];
        if (h == 6'd0)
            result = {3'b000, ql};
        else
            result = {qh, a_sat};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            final_op  <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                final_op <= result;
        end
    end

endmodule

// File: tb/tb_squareroot_ahsqr_k10.sv
// Scoreboarded bench for squareroot_ahsqr_k10: directed boundaries, reset,
// valid gaps, random traffic and an exhaustive sweep against a formula model.
module tb_squareroot_ahsqr_k10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] R;
    logic [7:0]  final_op;
    logic        out_valid;

    typedef struct packed {
        logic       vld;
        logic [7:0] op;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] model_hold = 8'd0;
    int n_checks = 0;
    int n_fail   = 0;
    int n_popped = 0;
    int n_pushed = 0;

    squareroot_ahsqr_k10 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .R         (R),
        .final_op  (final_op),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Formula model: integer searches, no bit-level iteration.
    function automatic logic [7:0] ref_sqrt(input int r);
        int h, l, qh, s, rem, x, p, a;
        h = r / 1024;
        l = r % 1024;
        if (h == 0) begin
            s = 0;
            while ((s + 1) * (s + 1) <= l) s++;
            return 8'(s);
        end
        qh = 0;
        while ((qh + 1) * (qh + 1) <= h) qh++;
        rem = h - qh * qh;
        x   = rem * 1024 + l;
        p   = (qh >= 4) ? 2 : ((qh >= 2) ? 1 : 0);
        a   = x / (1 << (6 + p));
        if (a > 31) a = 31;
        return 8'(qh * 32 + a);
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue what the next rising edge must produce.
    task automatic cycle(input logic c_rst, input logic c_vld, input logic [15:0] c_r,
                         input bit use_const, input logic [7:0] c_exp);
        exp_t e;
        rst      = c_rst;
        in_valid = c_vld;
        R        = c_r;
        if (c_rst) begin
            model_hold = 8'd0;
            e.vld = 1'b0;
        end else if (c_vld) begin
            model_hold = use_const ? c_exp : ref_sqrt(int'(c_r));
            e.vld = 1'b1;
        end else begin
            e.vld = 1'b0;
        end
        e.op = model_hold;
        exp_q.push_back(e);
        n_pushed++;
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_popped++;
                n_checks++;
                if (out_valid !== e.vld) begin
                    n_fail++;
                    $display("FAIL out_valid at %0t: got %b expected %b", $time, out_valid, e.vld);
                end
                n_checks++;
                if (final_op !== e.op) begin
                    n_fail++;
                    $display("FAIL final_op at %0t: got %0d expected %0d (out_valid exp %b)",
                             $time, final_op, e.op, e.vld);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, popped %0d of %0d", n_popped, n_pushed);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int er_cnt, ed, ed_max, t, ap;
        real sum_ed, sum_red;
        er_cnt = 0; ed_max = 0; sum_ed = 0.0; sum_red = 0.0;

        // Reset overrides a valid sample.
        repeat (3) cycle(1'b1, 1'b1, 16'hFFFF, 1'b1, 8'd0);

        // Exact boundaries back-to-back, first one right after reset release.
        cycle(1'b0, 1'b1, 16'd0,     1'b1, 8'd0);
        cycle(1'b0, 1'b1, 16'd1023,  1'b1, 8'd31);
        cycle(1'b0, 1'b1, 16'd1024,  1'b1, 8'd32);
        cycle(1'b0, 1'b1, 16'd4096,  1'b1, 8'd64);
        cycle(1'b0, 1'b1, 16'd65535, 1'b1, 8'd255);

        // Approximation and saturation points.
        cycle(1'b0, 1'b1, 16'd3071,  1'b1, 8'd63);
        cycle(1'b0, 1'b1, 16'd40000, 1'b1, 8'd204);
        cycle(1'b0, 1'b1, 16'd65535, 1'b1, 8'd255);

        // Alternating valid with changing R; gap R is arbitrary.
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 1'(i % 2 == 0), 16'($urandom), 1'b0, 8'd0);

        // Mid-run reset discards a sample and clears the output.
        cycle(1'b0, 1'b1, 16'd50000, 1'b0, 8'd0);
        cycle(1'b1, 1'b1, 16'd12345, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 16'($urandom), 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 16'd2000, 1'b0, 8'd0);

        // Random traffic with random valid density.
        for (int i = 0; i < 300; i++)
            cycle(1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'b0, 8'd0);

        // Exhaustive sweep with characterisation.
        for (int r = 0; r < 65536; r++) begin
            ap = int'(ref_sqrt(r));
            t  = $rtoi($sqrt(real'(r)));
            ed = (ap > t) ? ap - t : t - ap;
            if (ed != 0) er_cnt++;
            if (ed > ed_max) ed_max = ed;
            sum_ed += real'(ed);
            if (t > 0) sum_red += real'(ed) / real'(t);
            cycle(1'b0, 1'b1, 16'(r), 1'b0, 8'd0);
        end
        cycle(1'b0, 1'b0, 16'd0, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 16'd0, 1'b0, 8'd0);
        @(negedge clk);

        n_checks++;
        if (exp_q.size() != 0 || n_popped != n_pushed) begin
            n_fail++;
            $display("FAIL scoreboard drain: popped %0d pushed %0d left %0d", n_popped, n_pushed, exp_q.size());
        end

        $display("Characterisation: ER=%f NMED=%f MRED=%f EDmax=%0d",
                 real'(er_cnt) / 65536.0, sum_ed / (255.0 * 65536.0),
                 sum_red / 65536.0, ed_max);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
